clkmgr_gate_seq: RTL and testbench

Sequencer that turns a family of gated clocks on or off in response to a single request level. It staggers the individual clock enables to limit supply current steps. It then waits for the synchronized, debounced family status to confirm the transition, with a bounded timeout. It sits in the clock manager between the software/hint request register and the clock gating cells, and consumes the aggregate family status produced by the clock-status filter.

---
 rtl/clkmgr_gate_seq.sv | 147 ++++++++++++++
 tb/tb_clkmgr_gate_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clkmgr_gate_seq.sv
// Staggered enable sequencer for one gated-clock family: ramps thermometer-coded
// gate enables up or down, then waits (bounded) for the family status to confirm.
module clkmgr_gate_seq #(
  parameter int NumClocks     = 4,
  parameter int StaggerCycles = 2,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_req_i,
  input  logic                 status_i,
  output logic [NumClocks-1:0] clk_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int CntW = $clog2(NumClocks + 1);
  localparam int StW  = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
  localparam int TcW  = $clog2(TimeoutCycles);

  localparam logic [CntW-1:0] CntFull = CntW'(NumClocks);
  localparam logic [StW-1:0]  StLast  = StW'(StaggerCycles - 1);
  localparam logic [TcW-1:0]  TcLast  = TcW'(TimeoutCycles - 1);

  localparam logic [2:0] StOff      = 3'd0;
  localparam logic [2:0] StRampUp   = 3'd1;
  localparam logic [2:0] StWaitOn   = 3'd2;
  localparam logic [2:0] StOn       = 3'd3;
  localparam logic [2:0] StRampDown = 3'd4;
  localparam logic [2:0] StWaitOff  = 3'd5;

  logic [2:0]           state_reg, state_next;
  logic [CntW-1:0]      cnt_reg, cnt_next;
  logic [StW-1:0]       st_reg, st_next;
  logic [TcW-1:0]       tc_reg, tc_next;
  logic [NumClocks-1:0] clk_en_reg, clk_en_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic                 step_up, step_down;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    st_next    = st_reg;
    tc_next    = tc_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    step_up    = 1'b0;
    step_down  = 1'b0;

    // A request reversal always wins over confirmation and timeout.
    case (state_reg)
      StOff:  step_up = en_req_i;
      StOn:   step_down = !en_req_i;
      StRampUp: begin
        if (!en_req_i)              step_down = 1'b1;
        else if (st_reg == StLast)  step_up = 1'b1;
        else                        st_next = st_reg + StW'(1);
      end
      StRampDown: begin
        if (en_req_i)               step_up = 1'b1;
        else if (st_reg == StLast)  step_down = 1'b1;
        else                        st_next = st_reg + StW'(1);
      end
      StWaitOn: begin
        if (!en_req_i) begin
          step_down = 1'b1;
        end else if (status_i) begin
          state_next = StOn;
          done_next  = 1'b1;
        end else if (tc_reg == TcLast) begin
          state_next = StOn;
          err_next   = 1'b1;
        end else begin
          tc_next = tc_reg + TcW'(1);
        end
      end
      StWaitOff: begin
        if (en_req_i) begin
          step_up = 1'b1;
        end else if (!status_i) begin
          state_next = StOff;
          done_next  = 1'b1;
        end else if (tc_reg == TcLast) begin
          state_next = StOff;
          err_next   = 1'b1;
        end else begin
          tc_next = tc_reg + TcW'(1);
        end
      end
      default: state_next = StOff;
    endcase

    if (step_up) begin
      cnt_next = cnt_reg + CntW'(1);
      st_next  = '0;
      if (cnt_reg + CntW'(1) == CntFull) begin
        state_next = StWaitOn;
        tc_next    = '0;
      end else begin
        state_next = StRampUp;
      end
    end else if (step_down) begin
      cnt_next = cnt_reg - CntW'(1);
      st_next  = '0;
      if (cnt_reg - CntW'(1) == '0) begin
        state_next = StWaitOff;
        tc_next    = '0;
      end else begin
        state_next = StRampDown;
      end
    end
  end

  // Enables are registered straight from the next step count.
  for (genvar gi = 0; gi < NumClocks; gi++) begin : g_therm
    assign clk_en_next[gi] = (cnt_next > CntW'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= StOff;
      cnt_reg    <= '0;
      st_reg     <= '0;
      tc_reg     <= '0;
      clk_en_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      st_reg     <= st_next;
      tc_reg     <= tc_next;
      clk_en_reg <= clk_en_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  assign clk_en_o = clk_en_reg;
  assign done_o   = done_reg;
  assign err_o    = err_reg;
  assign busy_o   = (state_reg == StRampUp) || (state_reg == StWaitOn) ||
                    (state_reg == StRampDown) || (state_reg == StWaitOff);

endmodule

// File: tb/tb_clkmgr_gate_seq.sv
// Directed plus randomized check of clkmgr_gate_seq against a count/age based
// reference model of the enable sequence.
module tb_clkmgr_gate_seq;
  localparam int N = 4;
  localparam int S = 2;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         status = 1'b0;
  logic [N-1:0] clk_en;
  logic         busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: number of enabled clocks, edges since last step,
  // edges spent waiting, and whether the family has settled.
  int m_cnt, m_age, m_wait;
  bit m_prev_on, m_settled, m_done, m_err;

  clkmgr_gate_seq #(
    .NumClocks(N), .StaggerCycles(S), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_req_i(en), .status_i(status),
    .clk_en_o(clk_en), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] thermo(input int c);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < c; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_age = 0; m_wait = 0;
    m_prev_on = 1'b0; m_settled = 1'b1; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit s);
    int tgt;
    tgt = e ? N : 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_cnt != tgt) begin
      m_age++;
      if (e != m_prev_on || m_age >= S) begin
        m_cnt     = e ? m_cnt + 1 : m_cnt - 1;
        m_age     = 0;
        m_wait    = 0;
        m_settled = 1'b0;
      end
    end else if (!m_settled) begin
      if (s == e) begin
        m_settled = 1'b1;
        m_done    = 1'b1;
      end else begin
        m_wait++;
        if (m_wait == T) begin
          m_settled = 1'b1;
          m_err     = 1'b1;
        end
      end
    end
    m_prev_on = e;
  endtask

  task automatic cyc(input bit e, input bit s);
    en = e;
    status = s;
    @(posedge clk);
    model_edge(e, s);
    #1;
    $display("t=%0t en=%0b st=%0b clk_en=%b busy=%0b done=%0b err=%0b", $time, e, s, clk_en, busy, done, err);
    chk("clk_en", 32'(clk_en), 32'(thermo(m_cnt)));
    chk("busy", 32'(busy), 32'(!m_settled));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("excl", 32'(done & err), 32'd0);
  endtask

  logic [N-1:0] up_tbl [7];
  logic [N-1:0] dn_tbl [7];
  bit r_en, r_st;

  initial begin
    up_tbl = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111};
    dn_tbl = '{4'b0111, 4'b0111, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
    model_reset();

    #12;
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp up with status low, then confirm.
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 1'b0);
      chk("up_ramp", 32'(clk_en), 32'(up_tbl[k]));
      chk("up_busy", 32'(busy), 32'd1);
    end
    cyc(1'b1, 1'b1);
    chk("up_done", 32'(done), 32'd1);
    chk("up_idle", 32'(busy), 32'd0);
    cyc(1'b1, 1'b1);
    chk("up_done_pulse", 32'(done), 32'd0);

    // Ramp down with status high, then confirm.
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b1);
      chk("dn_ramp", 32'(clk_en), 32'(dn_tbl[k]));
    end
    cyc(1'b0, 1'b0);
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_idle", 32'(busy), 32'd0);

    // Timeout waiting for status to go high.
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0);
    for (int k = 1; k <= T; k++) begin
      cyc(1'b1, 1'b0);
      chk("to_err", 32'(err), 32'(k == T));
      chk("to_nodone", 32'(done), 32'd0);
    end
    chk("to_clk_en", 32'(clk_en), 32'hf);
    chk("to_idle", 32'(busy), 32'd0);

    // Back to OFF, then reverse mid-ramp at 0011.
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    chk("rev_pre", 32'(clk_en), 32'h3);
    cyc(1'b0, 1'b0);
    chk("rev_step", 32'(clk_en), 32'h1);
    chk("rev_busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rev_off", 32'(clk_en), 32'h0);
    chk("rev_wait", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0);
    chk("rev_done", 32'(done), 32'd1);

    // Reversal beats confirmation in WAIT_ON.
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("prio_nodone", 32'(done), 32'd0);
    chk("prio_step", 32'(clk_en), 32'h7);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0);

    // Asynchronous reset mid-ramp.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
    chk("mr_pre", 32'(clk_en), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_clk_en", 32'(clk_en), 32'd0);
    chk("mr_outs", 32'({busy, done, err}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    chk("mr_restart", 32'(clk_en), 32'h1);

    // Randomized request/status traffic.
    r_en = 1'b1;
    r_st = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) r_en = ~r_en;
      if ($urandom_range(0, 5) == 0) r_st = ~r_st;
      cyc(r_en, r_st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
